// File: rtl/hazard_if.sv
// Hazard-controller bus: ID-stage decode fields, branch/memory status in,
// stall/flush/forward controls out.
interface hazard_if;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       id_reg_write;
    logic [1:0] id_wb_sel;
    logic       ex_branch_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       pc_stall;
    logic       if_id_stall;
    logic       ex_mem_stall;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       mem_timeout;

    // Pipeline side: drives decode/status, receives hazard controls.
    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_reg_write, id_wb_sel, ex_branch_taken, mem_req, mem_ready,
        input  pc_stall, if_id_stall, ex_mem_stall, if_id_flush,
               id_ex_bubble, fwd_a, fwd_b, mem_timeout
    );

    // Hazard controller side.
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_reg_write, id_wb_sel, ex_branch_taken, mem_req, mem_ready,
        output pc_stall, if_id_stall, ex_mem_stall, if_id_flush,
               id_ex_bubble, fwd_a, fwd_b, mem_timeout
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: memory-wait stall, branch flush,
// load-use interlock and EX operand forwarding from a registered scoreboard.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   RUN       | pipeline flowing; memory access not yet waiting
//   MEM_WAIT  | memory access outstanding; counts wait cycles for timeout
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic    clk,
    input  logic    rst_n,
    hazard_if.slave bus
);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       load;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
    } ex_ent_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       load;
    } mem_ent_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
    } wb_ent_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_done_q, timeout_done_d;
    logic       branch_pend_q, branch_pend_d;
    ex_ent_t    ex_q, ex_d;
    mem_ent_t   mem_q, mem_d;
    wb_ent_t    wb_q, wb_d;

    logic       mem_stall;
    logic       branch_eff;
    logic       load_use;
    logic       timeout_hit;

    logic       pc_stall_c, if_id_stall_c, ex_mem_stall_c;
    logic       if_id_flush_c, id_ex_bubble_c, mem_timeout_c;
    logic [1:0] fwd_a_c, fwd_b_c;

    // MEM result (non-load) beats WB; r0 and invalid EX never forward.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       use_src,
        input ex_ent_t    ex,
        input mem_ent_t   mem,
        input wb_ent_t    wb
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (ex.valid && use_src) begin
            if (mem.valid && mem.wr && !mem.load && (mem.rd != 5'd0) && (mem.rd == rs))
                sel = 2'b10;
            else if (wb.valid && wb.wr && (wb.rd != 5'd0) && (wb.rd == rs))
                sel = 2'b01;
        end
        return sel;
    endfunction

    assign mem_stall   = bus.mem_req & ~bus.mem_ready;
    // A branch seen while memory-stalled is remembered and flushed on release.
    assign branch_eff  = bus.ex_branch_taken | branch_pend_q;
    assign load_use    = bus.id_valid & ex_q.valid & ex_q.load & ex_q.wr & (ex_q.rd != 5'd0) &
                         ((bus.id_use_rs1 & (bus.id_rs1 == ex_q.rd)) |
                          (bus.id_use_rs2 & (bus.id_rs2 == ex_q.rd)));
    // Saturated count never rearms the pulse; timeout_done_q blocks repeats.
    assign timeout_hit = (state_q == ST_MEM_WAIT) && (wait_cnt_q == TIMEOUT_CNT) && !timeout_done_q;

    // State, wait counter and scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= 8'd0;
            timeout_done_q <= 1'b0;
            branch_pend_q  <= 1'b0;
            ex_q           <= '0;
            mem_q          <= '0;
            wb_q           <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            timeout_done_q <= timeout_done_d;
            branch_pend_q  <= branch_pend_d;
            ex_q           <= ex_d;
            mem_q          <= mem_d;
            wb_q           <= wb_d;
        end
    end

    // Next state and memory-wait counter.
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        timeout_done_d = timeout_done_q;
        case (state_q)
            ST_RUN: begin
                wait_cnt_d     = 8'd0;
                timeout_done_d = 1'b0;
                if (mem_stall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.mem_ready) begin
                    state_d        = ST_RUN;
                    wait_cnt_d     = 8'd0;
                    timeout_done_d = 1'b0;
                end else begin
                    wait_cnt_d     = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
                    timeout_done_d = timeout_done_q | timeout_hit;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // Prioritised hazard outputs: memory stall, then branch, then load-use.
    always_comb begin
        pc_stall_c     = 1'b0;
        if_id_stall_c  = 1'b0;
        ex_mem_stall_c = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_bubble_c = 1'b0;
        if (mem_stall) begin
            pc_stall_c     = 1'b1;
            if_id_stall_c  = 1'b1;
            ex_mem_stall_c = 1'b1;
        end else if (branch_eff) begin
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
        end else if (load_use) begin
            pc_stall_c     = 1'b1;
            if_id_stall_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
        end
        fwd_a_c       = fwd_sel(ex_q.rs1, ex_q.use1, ex_q, mem_q, wb_q);
        fwd_b_c       = fwd_sel(ex_q.rs2, ex_q.use2, ex_q, mem_q, wb_q);
        mem_timeout_c = timeout_hit;
    end

    // Scoreboard advance and deferred-branch latch; everything holds while memory stalls.
    always_comb begin
        ex_d          = ex_q;
        mem_d         = mem_q;
        wb_d          = wb_q;
        branch_pend_d = 1'b0;
        if (mem_stall) begin
            branch_pend_d = branch_pend_q | bus.ex_branch_taken;
        end else begin
            wb_d  = '{valid: mem_q.valid, rd: mem_q.rd, wr: mem_q.wr};
            mem_d = '{valid: ex_q.valid, rd: ex_q.rd, wr: ex_q.wr, load: ex_q.load};
            if (id_ex_bubble_c || !bus.id_valid) begin
                ex_d = '0;
            end else begin
                ex_d = '{valid: 1'b1,
                         rd:    bus.id_rd,
                         wr:    bus.id_reg_write,
                         load:  (bus.id_wb_sel == 2'b01),
                         rs1:   bus.id_rs1,
                         rs2:   bus.id_rs2,
                         use1:  bus.id_use_rs1,
                         use2:  bus.id_use_rs2};
            end
        end
    end

    // Reset forces every output low immediately, even with a stall request present.
    assign bus.pc_stall     = rst_n & pc_stall_c;
    assign bus.if_id_stall  = rst_n & if_id_stall_c;
    assign bus.ex_mem_stall = rst_n & ex_mem_stall_c;
    assign bus.if_id_flush  = rst_n & if_id_flush_c;
    assign bus.id_ex_bubble = rst_n & id_ex_bubble_c;
    assign bus.fwd_a        = rst_n ? fwd_a_c : 2'b00;
    assign bus.fwd_b        = rst_n ? fwd_b_c : 2'b00;
    assign bus.mem_timeout  = rst_n & mem_timeout_c;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus random traffic,
// every cycle compared with an instruction-level pipeline model.
module tb_hazard_ctrl;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_if hif();

    hazard_ctrl #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif.slave)
    );

    typedef struct {
        bit valid;
        int rd;
        int rs1;
        int rs2;
        bit use1;
        bit use2;
        bit wr;
        bit load;
    } ins_t;

    // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
    ins_t pipe[3];
    bit   m_wait;
    int   m_cnt;
    bit   m_pend;
    bit   e_stall, e_br, e_lu;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    function automatic ins_t empty_ins();
        ins_t e;
        e = '{valid: 1'b0, rd: 0, rs1: 0, rs2: 0, use1: 1'b0, use2: 1'b0, wr: 1'b0, load: 1'b0};
        return e;
    endfunction

    function automatic ins_t id_ins();
        ins_t e;
        e = '{valid: 1'b1, rd: int'(hif.id_rd), rs1: int'(hif.id_rs1), rs2: int'(hif.id_rs2),
              use1: hif.id_use_rs1, use2: hif.id_use_rs2, wr: hif.id_reg_write,
              load: (hif.id_wb_sel == 2'b01)};
        return e;
    endfunction

    function automatic logic [1:0] m_fwd(input int rs, input bit use_src);
        if (!pipe[0].valid || !use_src || rs == 0) return 2'b00;
        if (pipe[1].valid && pipe[1].wr && !pipe[1].load && pipe[1].rd == rs) return 2'b10;
        if (pipe[2].valid && pipe[2].wr && pipe[2].rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = empty_ins();
        m_wait = 1'b0;
        m_cnt  = 0;
        m_pend = 1'b0;
    endtask

    task automatic set_id(input bit v, input int rd, input int rs1, input int rs2,
                          input bit u1, input bit u2, input bit wr, input logic [1:0] sel);
        hif.id_valid     = v;
        hif.id_rd        = 5'(rd);
        hif.id_rs1       = 5'(rs1);
        hif.id_rs2       = 5'(rs2);
        hif.id_use_rs1   = u1;
        hif.id_use_rs2   = u2;
        hif.id_reg_write = wr;
        hif.id_wb_sel    = sel;
    endtask

    task automatic idle();
        set_id(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 2'b00);
        hif.ex_branch_taken = 1'b0;
        hif.mem_req         = 1'b0;
        hif.mem_ready       = 1'b0;
    endtask

    // Sample on the falling edge and compare all outputs with the model.
    task automatic step(input string tag);
        bit hit;
        @(negedge clk);
        e_stall = hif.mem_req && !hif.mem_ready;
        e_br    = !e_stall && (hif.ex_branch_taken || m_pend);
        hit     = pipe[0].valid && pipe[0].load && pipe[0].wr && pipe[0].rd != 0 &&
                  ((hif.id_use_rs1 && int'(hif.id_rs1) == pipe[0].rd) ||
                   (hif.id_use_rs2 && int'(hif.id_rs2) == pipe[0].rd));
        e_lu    = !e_stall && !e_br && hif.id_valid && hit;
        chk({tag, ".pc_stall"},     hif.pc_stall,     e_stall || e_lu);
        chk({tag, ".if_id_stall"},  hif.if_id_stall,  e_stall || e_lu);
        chk({tag, ".ex_mem_stall"}, hif.ex_mem_stall, e_stall);
        chk({tag, ".if_id_flush"},  hif.if_id_flush,  e_br);
        chk({tag, ".id_ex_bubble"}, hif.id_ex_bubble, e_br || e_lu);
        chk({tag, ".fwd_a"},        hif.fwd_a,        m_fwd(pipe[0].rs1, pipe[0].use1));
        chk({tag, ".fwd_b"},        hif.fwd_b,        m_fwd(pipe[0].rs2, pipe[0].use2));
        chk({tag, ".mem_timeout"},  hif.mem_timeout,  m_wait && m_cnt == TO);
    endtask

    // Advance the model across the rising edge using the inputs of this cycle.
    task automatic tick();
        @(posedge clk);
        if (!m_wait) begin
            if (e_stall) begin
                m_wait = 1'b1;
                m_cnt  = 1;
            end
        end else if (hif.mem_ready) begin
            m_wait = 1'b0;
            m_cnt  = 0;
        end else begin
            m_cnt++;
        end
        m_pend = e_stall ? (m_pend || hif.ex_branch_taken) : 1'b0;
        if (!e_stall) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (e_br || e_lu || !hif.id_valid) ? empty_ins() : id_ins();
        end
        #1;
    endtask

    task automatic cyc(input string tag);
        step(tag);
        tick();
    endtask

    initial begin
        bit prev_req;
        model_reset();
        idle();
        hif.mem_req = 1'b1;
        #12;
        chk("rst.pc_stall",     hif.pc_stall,     1'b0);
        chk("rst.ex_mem_stall", hif.ex_mem_stall, 1'b0);
        chk("rst.fwd_a",        hif.fwd_a,        2'b00);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("rst_idle");

        // lw x5 ; add x6,x5,x7
        set_id(1, 5, 1, 0, 1, 0, 1, 2'b01);
        cyc("lu_lw");
        set_id(1, 6, 5, 7, 1, 1, 1, 2'b00);
        step("lu_add");
        chk("lu.stall_now", hif.pc_stall, 1'b1);
        chk("lu.bubble_now", hif.id_ex_bubble, 1'b1);
        tick();
        step("lu_add_retry");
        chk("lu.one_cycle", hif.pc_stall, 1'b0);
        tick();
        idle();
        step("lu_ex");
        chk("lu.fwd_a_wb", hif.fwd_a, 2'b01);
        tick();
        for (int i = 0; i < 3; i++) cyc("drain");

        // add x5 ; sub x6,x5,x5 back to back
        set_id(1, 5, 1, 2, 1, 1, 1, 2'b00);
        cyc("b2b_add");
        set_id(1, 6, 5, 5, 1, 1, 1, 2'b00);
        step("b2b_sub");
        chk("b2b.no_stall", hif.pc_stall, 1'b0);
        tick();
        idle();
        step("b2b_ex");
        chk("b2b.fwd_a", hif.fwd_a, 2'b10);
        chk("b2b.fwd_b", hif.fwd_b, 2'b10);
        tick();
        for (int i = 0; i < 3; i++) cyc("drain");

        // add x5 ; unrelated ; sub x6,x5,x5
        set_id(1, 5, 1, 2, 1, 1, 1, 2'b00);
        cyc("gap_add");
        set_id(1, 9, 10, 11, 1, 1, 1, 2'b00);
        cyc("gap_other");
        set_id(1, 6, 5, 5, 1, 1, 1, 2'b00);
        cyc("gap_sub");
        idle();
        step("gap_ex");
        chk("gap.fwd_a", hif.fwd_a, 2'b01);
        chk("gap.fwd_b", hif.fwd_b, 2'b01);
        tick();
        for (int i = 0; i < 3; i++) cyc("drain");

        // addi x0,x0,1 ; add x1,x0,x0
        set_id(1, 0, 0, 0, 1, 0, 1, 2'b00);
        cyc("x0_addi");
        set_id(1, 1, 0, 0, 1, 1, 1, 2'b00);
        cyc("x0_add");
        idle();
        step("x0_ex");
        chk("x0.fwd_a", hif.fwd_a, 2'b00);
        chk("x0.fwd_b", hif.fwd_b, 2'b00);
        tick();
        for (int i = 0; i < 3; i++) cyc("drain");

        // three-cycle memory stall with a forwarding pair frozen in place
        set_id(1, 5, 1, 2, 1, 1, 1, 2'b00);
        cyc("ms_p");
        set_id(1, 6, 5, 0, 1, 0, 1, 2'b00);
        cyc("ms_c");
        idle();
        hif.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("ms_wait");
            chk("ms.stall", hif.ex_mem_stall, 1'b1);
            chk("ms.frozen_fwd", hif.fwd_a, 2'b10);
            tick();
        end
        hif.mem_ready = 1'b1;
        step("ms_done");
        chk("ms.released", hif.pc_stall, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) cyc("ms_after");

        // branch during memory stall is flushed on release
        hif.mem_req = 1'b1;
        hif.ex_branch_taken = 1'b1;
        step("db_wait");
        chk("db.no_flush", hif.if_id_flush, 1'b0);
        tick();
        hif.ex_branch_taken = 1'b0;
        hif.mem_ready = 1'b1;
        step("db_rel");
        chk("db.flush", hif.if_id_flush, 1'b1);
        tick();
        idle();
        cyc("db_after");

        // timeout pulse, then reset in the middle of MEM_WAIT
        hif.mem_req = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step("to_wait");
            chk("to.pulse", hif.mem_timeout, (i == TO + 1) ? 1'b1 : 1'b0);
            tick();
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("to_rst.pc_stall",     hif.pc_stall,     1'b0);
        chk("to_rst.if_id_stall",  hif.if_id_stall,  1'b0);
        chk("to_rst.ex_mem_stall", hif.ex_mem_stall, 1'b0);
        chk("to_rst.mem_timeout",  hif.mem_timeout,  1'b0);
        model_reset();
        @(posedge clk);
        #2;
        idle();
        rst_n = 1'b1;
        #1;
        cyc("to_rst_run");
        hif.mem_req = 1'b1;
        for (int i = 1; i <= TO + 1; i++) cyc("to_rearm");
        idle();
        hif.mem_ready = 1'b1;
        cyc("to_rel");
        idle();

        // branch coinciding with load-use: flush only
        set_id(1, 5, 1, 0, 1, 0, 1, 2'b01);
        cyc("bl_lw");
        set_id(1, 6, 5, 7, 1, 1, 1, 2'b00);
        hif.ex_branch_taken = 1'b1;
        step("bl_both");
        chk("bl.flush", hif.if_id_flush, 1'b1);
        chk("bl.bubble", hif.id_ex_bubble, 1'b1);
        chk("bl.no_pc_stall", hif.pc_stall, 1'b0);
        tick();
        idle();
        cyc("bl_after");

        // random traffic
        prev_req = 1'b0;
        for (int n = 0; n < 600; n++) begin
            set_id(($urandom % 4) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom),
                   2'($urandom));
            hif.ex_branch_taken = ($urandom % 8) == 0;
            hif.mem_req         = (($urandom % 6) == 0) || (prev_req && ($urandom % 5) != 0);
            hif.mem_ready       = ($urandom % 4) == 0;
            prev_req            = hif.mem_req;
            cyc("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
